// File: rtl/wm_plant_responder_if.sv
//==============================================================================
// Module : wm_plant_responder_if
// Brief  : Command/feedback bundle between washer controller and plant model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface wm_plant_responder_if #(
    parameter int LEVEL_W = 8
);
    logic               valve_in_cold;
    logic               valve_in_hot;
    logic               valve_out;
    logic [1:0]         motor;
    logic               lock_door;
    logic               soap_in;
    logic               door_closed_in;
    logic               fault_clr;
    logic [LEVEL_W-1:0] water_level;
    logic               level_full;
    logic               level_empty;
    logic               door_locked;
    logic [1:0]         motor_state;
    logic [1:0]         temp_code;
    logic               soap_available;
    logic               fault;
    logic [1:0]         fault_code;

    modport master (
        output valve_in_cold, valve_in_hot, valve_out, motor, lock_door,
               soap_in, door_closed_in, fault_clr,
        input  water_level, level_full, level_empty, door_locked, motor_state,
               temp_code, soap_available, fault, fault_code
    );

    modport slave (
        input  valve_in_cold, valve_in_hot, valve_out, motor, lock_door,
               soap_in, door_closed_in, fault_clr,
        output water_level, level_full, level_empty, door_locked, motor_state,
               temp_code, soap_available, fault, fault_code
    );
endinterface

`default_nettype wire

// File: rtl/wm_plant_responder.sv
//==============================================================================
// Module : wm_plant_responder
// Brief  : Washer plant model: tank level, door latch, drum interlocks, faults.
//          Optional soap dose counter enabled by macro WM_SOAP_LEVEL_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module wm_plant_responder #(
    parameter int LEVEL_W    = 8,
    parameter int LEVEL_MAX  = 200,
    parameter int FILL_RATE  = 4,
    parameter int DRAIN_RATE = 5,
    parameter int LOCK_DELAY = 3,
    parameter int SPIN_RAMP  = 4
`ifdef WM_SOAP_LEVEL_EN
    ,
    parameter int SOAP_DOSES = 5
`endif
) (
    input  wire                    clk,
    input  wire                    rst,
    wm_plant_responder_if.slave    bus
);

    typedef logic signed [LEVEL_W+1:0] lvl_t;
    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        LOCKING   = 2'd1,
        LOCKED    = 2'd2,
        UNLOCKING = 2'd3
    } latch_t;

    localparam int C_LCW = (LOCK_DELAY < 1) ? 1 : $clog2(LOCK_DELAY + 1);
    localparam int C_RW  = (SPIN_RAMP < 1) ? 1 : $clog2(SPIN_RAMP + 1);
    localparam logic [LEVEL_W-1:0] C_LEVEL_MAX = LEVEL_W'(LEVEL_MAX);
    localparam lvl_t               C_FILL      = lvl_t'(FILL_RATE);
    localparam lvl_t               C_DRAIN     = lvl_t'(DRAIN_RATE);
    localparam lvl_t               C_MAX_S     = lvl_t'(LEVEL_MAX);
    localparam logic [C_LCW-1:0]   C_LOCK      = C_LCW'(LOCK_DELAY);
    localparam logic [C_LCW-1:0]   C_LOCK_ONE  = C_LCW'(1);
    localparam logic [C_RW-1:0]    C_RAMP      = C_RW'(SPIN_RAMP);
    localparam logic [C_RW-1:0]    C_RAMP_ONE  = C_RW'(1);

    logic [LEVEL_W-1:0] level_q, level_d;
    logic               level_full_q, level_full_d;
    logic               level_empty_q, level_empty_d;
    logic [1:0]         temp_q, temp_d;
    latch_t             state_q, state_d;
    logic [C_LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic               door_locked_q, door_locked_d;
    logic [1:0]         motor_state_q, motor_state_d;
    logic [C_RW-1:0]    ramp_q, ramp_d;
    logic               fault_q, fault_d;
    logic [1:0]         fault_code_q, fault_code_d;

    lvl_t               w_in;
    lvl_t               w_out;
    lvl_t               w_sum;
    logic               w_c1, w_c2, w_c3;
    logic [1:0]         w_new_code;

    always_comb begin
        w_in  = (bus.valve_in_cold ? C_FILL : lvl_t'(0)) + (bus.valve_in_hot ? C_FILL : lvl_t'(0));
        w_out = bus.valve_out ? C_DRAIN : lvl_t'(0);
        w_sum = lvl_t'({2'b00, level_q}) + w_in - w_out;

        level_d = level_q;
        if (w_sum < lvl_t'(0)) begin
            level_d = '0;
        end else if (w_sum > C_MAX_S) begin
            level_d = C_LEVEL_MAX;
        end else begin
            level_d = w_sum[LEVEL_W-1:0];
        end
        level_full_d  = (level_d >= C_LEVEL_MAX);
        level_empty_d = (level_d == '0);

        // An emptied tank forgets its water temperature even if an inlet is open.
        temp_d = temp_q;
        if (level_d == '0) begin
            temp_d = 2'd0;
        end else if (bus.valve_in_cold || bus.valve_in_hot) begin
            temp_d = {bus.valve_in_hot, bus.valve_in_cold};
        end

        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            UNLOCKED: begin
                if (bus.lock_door && bus.door_closed_in) begin
                    state_d    = LOCKING;
                    lock_cnt_d = C_LOCK;
                end
            end
            LOCKING: begin
                if (!bus.lock_door || !bus.door_closed_in) begin
                    state_d = UNLOCKED;
                end else if (lock_cnt_q <= C_LOCK_ONE) begin
                    state_d    = LOCKED;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - C_LOCK_ONE;
                end
            end
            LOCKED: begin
                if (!bus.lock_door && level_empty_q && (motor_state_q == 2'd0)) begin
                    state_d    = UNLOCKING;
                    lock_cnt_d = C_LOCK;
                end
            end
            UNLOCKING: begin
                if (bus.lock_door) begin
                    state_d    = LOCKING;
                    lock_cnt_d = C_LOCK;
                end else if (lock_cnt_q <= C_LOCK_ONE) begin
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - C_LOCK_ONE;
                end
            end
            default: state_d = UNLOCKED;
        endcase
        door_locked_d = (state_d == LOCKED);

        motor_state_d = 2'd0;
        ramp_d        = '0;
        if (door_locked_q) begin
            if (bus.motor == 2'd1) begin
                motor_state_d = 2'd1;
            end else if (bus.motor == 2'd2) begin
                motor_state_d = (ramp_q >= C_RAMP) ? 2'd2 : 2'd1;
                ramp_d        = (ramp_q >= C_RAMP) ? ramp_q : ramp_q + C_RAMP_ONE;
            end
        end

        w_c3 = (state_q == LOCKED) && !bus.door_closed_in;
        w_c2 = ((bus.motor != 2'd0) && !door_locked_q) || (bus.motor == 2'd3);
        w_c1 = (w_in != lvl_t'(0)) && (level_q == C_LEVEL_MAX);
        w_new_code = w_c3 ? 2'd3 : (w_c2 ? 2'd2 : (w_c1 ? 2'd1 : 2'd0));

        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        if (fault_q && bus.fault_clr) begin
            fault_d      = 1'b0;
            fault_code_d = 2'd0;
        end
        if ((w_c1 || w_c2 || w_c3) && (!fault_q || bus.fault_clr)) begin
            fault_d      = 1'b1;
            fault_code_d = w_new_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q       <= '0;
            level_full_q  <= 1'b0;
            level_empty_q <= 1'b1;
            temp_q        <= 2'd0;
            state_q       <= UNLOCKED;
            lock_cnt_q    <= '0;
            door_locked_q <= 1'b0;
            motor_state_q <= 2'd0;
            ramp_q        <= '0;
            fault_q       <= 1'b0;
            fault_code_q  <= 2'd0;
        end else begin
            level_q       <= level_d;
            level_full_q  <= level_full_d;
            level_empty_q <= level_empty_d;
            temp_q        <= temp_d;
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            door_locked_q <= door_locked_d;
            motor_state_q <= motor_state_d;
            ramp_q        <= ramp_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
        end
    end

`ifdef WM_SOAP_LEVEL_EN
    localparam int C_DW = (SOAP_DOSES < 1) ? 1 : $clog2(SOAP_DOSES + 1);
    localparam logic [C_DW-1:0] C_DOSES   = C_DW'(SOAP_DOSES);
    localparam logic [C_DW-1:0] C_DOSE_ONE = C_DW'(1);

    logic            soap_prev_q, soap_prev_d;
    logic [C_DW-1:0] dose_q, dose_d;
    logic            soap_avail_q, soap_avail_d;

    // Dispensing counts rising edges only, so a held soap_in uses one dose.
    always_comb begin
        soap_prev_d = bus.soap_in;
        dose_d      = dose_q;
        if (bus.soap_in && !soap_prev_q && (dose_q != '0)) begin
            dose_d = dose_q - C_DOSE_ONE;
        end
        soap_avail_d = (dose_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            soap_prev_q  <= 1'b0;
            dose_q       <= C_DOSES;
            soap_avail_q <= (C_DOSES != '0);
        end else begin
            soap_prev_q  <= soap_prev_d;
            dose_q       <= dose_d;
            soap_avail_q <= soap_avail_d;
        end
    end

    assign bus.soap_available = soap_avail_q;
`else
    logic w_unused_soap;
    assign w_unused_soap      = bus.soap_in;
    assign bus.soap_available = 1'b1;
`endif

    assign bus.water_level = level_q;
    assign bus.level_full  = level_full_q;
    assign bus.level_empty = level_empty_q;
    assign bus.door_locked = door_locked_q;
    assign bus.motor_state = motor_state_q;
    assign bus.temp_code   = temp_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fault_code_q;

endmodule

`default_nettype wire

// File: tb/tb_wm_plant_responder.sv
//==============================================================================
// Module : tb_wm_plant_responder
// Brief  : Directed self-checking bench for wm_plant_responder.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_wm_plant_responder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    wm_plant_responder_if #(.LEVEL_W(8)) bus ();

    wm_plant_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.valve_in_cold  = 1'b0;
        bus.valve_in_hot   = 1'b0;
        bus.valve_out      = 1'b0;
        bus.motor          = 2'd0;
        bus.lock_door      = 1'b0;
        bus.soap_in        = 1'b0;
        bus.door_closed_in = 1'b0;
        bus.fault_clr      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.water_level !== 8'd0) begin n_errors++; $display("FAIL reset_level: got %0d expected 0", bus.water_level); end
        n_checks++; if (bus.level_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %0b expected 1", bus.level_empty); end
        n_checks++; if ({bus.level_full, bus.door_locked, bus.fault} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {bus.level_full, bus.door_locked, bus.fault}); end
        n_checks++; if ({bus.motor_state, bus.temp_code, bus.fault_code} !== 6'd0) begin n_errors++; $display("FAIL reset_codes: got %b expected 000000", {bus.motor_state, bus.temp_code, bus.fault_code}); end
        n_checks++; if (bus.soap_available !== 1'b1) begin n_errors++; $display("FAIL reset_soap: got %0b expected 1", bus.soap_available); end
    endtask

    task automatic test_fill();
        do_reset();
        bus.valve_in_cold = 1'b1;
        step(10);
        n_checks++; if (bus.water_level !== 8'd40) begin n_errors++; $display("FAIL fill_cold_level: got %0d expected 40", bus.water_level); end
        n_checks++; if (bus.temp_code !== 2'd1) begin n_errors++; $display("FAIL fill_cold_temp: got %0d expected 1", bus.temp_code); end
        bus.valve_in_hot = 1'b1;
        step(20);
        n_checks++; if (bus.water_level !== 8'd200) begin n_errors++; $display("FAIL fill_full_level: got %0d expected 200", bus.water_level); end
        n_checks++; if ({bus.level_full, bus.fault, bus.temp_code} !== 4'b1011) begin n_errors++; $display("FAIL fill_full_flags: got %b expected 1011", {bus.level_full, bus.fault, bus.temp_code}); end
        step(1);
        n_checks++; if ({bus.fault, bus.fault_code} !== 3'b101) begin n_errors++; $display("FAIL overfill_fault: got %b expected 101", {bus.fault, bus.fault_code}); end
        n_checks++; if (bus.water_level !== 8'd200) begin n_errors++; $display("FAIL overfill_hold: got %0d expected 200", bus.water_level); end
        bus.valve_in_cold = 1'b0;
        bus.valve_in_hot  = 1'b0;
        bus.fault_clr     = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        n_checks++; if ({bus.fault, bus.fault_code} !== 3'b000) begin n_errors++; $display("FAIL overfill_clear: got %b expected 000", {bus.fault, bus.fault_code}); end
    endtask

    // Continues from the full tank left by test_fill.
    task automatic test_net_flow();
        bus.valve_out = 1'b1;
        step(20);
        n_checks++; if (bus.water_level !== 8'd100) begin n_errors++; $display("FAIL drain_to_100: got %0d expected 100", bus.water_level); end
        bus.valve_in_cold = 1'b1;
        bus.valve_in_hot  = 1'b1;
        step(4);
        n_checks++; if (bus.water_level !== 8'd112) begin n_errors++; $display("FAIL net_flow: got %0d expected 112", bus.water_level); end
        bus.valve_in_cold = 1'b0;
        bus.valve_in_hot  = 1'b0;
        step(22);
        n_checks++; if ({bus.water_level, bus.temp_code} !== {8'd2, 2'd3}) begin n_errors++; $display("FAIL drain_near_empty: got level %0d temp %0d expected 2 3", bus.water_level, bus.temp_code); end
        step(8);
        n_checks++; if ({bus.water_level, bus.level_empty, bus.temp_code} !== {8'd0, 1'b1, 2'd0}) begin n_errors++; $display("FAIL drain_empty: got level %0d empty %0b temp %0d expected 0 1 0", bus.water_level, bus.level_empty, bus.temp_code); end
        bus.valve_out = 1'b0;
    endtask

    task automatic test_latch();
        do_reset();
        bus.valve_in_cold = 1'b1;
        step(5);
        bus.valve_in_cold  = 1'b0;
        bus.lock_door      = 1'b1;
        bus.door_closed_in = 1'b1;
        step(3);
        n_checks++; if (bus.door_locked !== 1'b0) begin n_errors++; $display("FAIL latch_early: got %0b expected 0", bus.door_locked); end
        step(1);
        n_checks++; if (bus.door_locked !== 1'b1) begin n_errors++; $display("FAIL latch_engaged: got %0b expected 1", bus.door_locked); end
        bus.lock_door = 1'b0;
        step(2);
        n_checks++; if ({bus.door_locked, bus.water_level} !== {1'b1, 8'd20}) begin n_errors++; $display("FAIL latch_hold_water: got locked %0b level %0d expected 1 20", bus.door_locked, bus.water_level); end
        bus.valve_out = 1'b1;
        step(4);
        n_checks++; if ({bus.door_locked, bus.level_empty} !== 2'b11) begin n_errors++; $display("FAIL latch_at_empty: got %b expected 11", {bus.door_locked, bus.level_empty}); end
        step(1);
        n_checks++; if (bus.door_locked !== 1'b0) begin n_errors++; $display("FAIL latch_release: got %0b expected 0", bus.door_locked); end
        bus.valve_out = 1'b0;
    endtask

    task automatic test_interlock();
        do_reset();
        bus.motor = 2'd2;
        step(1);
        n_checks++; if ({bus.fault, bus.fault_code, bus.motor_state} !== 5'b11000) begin n_errors++; $display("FAIL interlock_unlocked: got %b expected 11000", {bus.fault, bus.fault_code, bus.motor_state}); end
        bus.motor          = 2'd0;
        bus.lock_door      = 1'b1;
        bus.door_closed_in = 1'b1;
        step(4);
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        n_checks++; if ({bus.door_locked, bus.fault} !== 2'b10) begin n_errors++; $display("FAIL interlock_cleared: got %b expected 10", {bus.door_locked, bus.fault}); end
        bus.motor = 2'd2;
        step(1);
        n_checks++; if (bus.motor_state !== 2'd1) begin n_errors++; $display("FAIL spin_ramp_first: got %0d expected 1", bus.motor_state); end
        step(3);
        n_checks++; if (bus.motor_state !== 2'd1) begin n_errors++; $display("FAIL spin_ramp_last: got %0d expected 1", bus.motor_state); end
        step(1);
        n_checks++; if ({bus.motor_state, bus.fault} !== 3'b100) begin n_errors++; $display("FAIL spin_reached: got %b expected 100", {bus.motor_state, bus.fault}); end
        bus.motor = 2'd3;
        step(1);
        n_checks++; if ({bus.fault, bus.fault_code, bus.motor_state} !== 5'b11000) begin n_errors++; $display("FAIL motor_illegal: got %b expected 11000", {bus.fault, bus.fault_code, bus.motor_state}); end
        bus.motor = 2'd0;
    endtask

    task automatic test_breach_and_reset();
        do_reset();
        bus.lock_door      = 1'b1;
        bus.door_closed_in = 1'b1;
        step(4);
        bus.door_closed_in = 1'b0;
        bus.motor          = 2'd3;
        step(1);
        n_checks++; if ({bus.fault, bus.fault_code, bus.door_locked} !== 4'b1111) begin n_errors++; $display("FAIL breach_priority: got %b expected 1111", {bus.fault, bus.fault_code, bus.door_locked}); end
        do_reset();
        bus.valve_in_cold = 1'b1;
        step(5);
        n_checks++; if (bus.water_level !== 8'd20) begin n_errors++; $display("FAIL midfill_level: got %0d expected 20", bus.water_level); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({bus.water_level, bus.level_empty, bus.temp_code, bus.fault} !== {8'd0, 1'b1, 2'd0, 1'b0}) begin n_errors++; $display("FAIL async_reset: got level %0d empty %0b temp %0d fault %0b expected 0 1 0 0", bus.water_level, bus.level_empty, bus.temp_code, bus.fault); end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_soap();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.soap_in = 1'b1;
            step(1);
            bus.soap_in = 1'b0;
            step(1);
`ifdef WM_SOAP_LEVEL_EN
            if (i == 3 || i == 4 || i == 5) begin
                n_checks++; if (bus.soap_available !== (i < 4)) begin n_errors++; $display("FAIL soap_pulse_%0d: got %0b expected %0b", i + 1, bus.soap_available, (i < 4)); end
            end
`else
            if (i == 5) begin
                n_checks++; if (bus.soap_available !== 1'b1) begin n_errors++; $display("FAIL soap_tied: got %0b expected 1", bus.soap_available); end
            end
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_fill();
        test_net_flow();
        test_latch();
        test_interlock();
        test_breach_and_reset();
        test_soap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
